// File: rtl/parking_sensor_gen.sv
// parking_sensor_gen: drives the two-beam parking sensor pair (sensor_a/sensor_b)
// through enter / exit / abort interruption sequences with a programmable
// per-phase dwell. Each phase lasts cmd_dwell+1 cycles.
module parking_sensor_gen #(
   parameter int unsigned DWELL_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cmd_valid,
   input  logic [1:0]         cmd_op,
   input  logic [DWELL_W-1:0] cmd_dwell,
   output logic               cmd_ready,
   output logic               sensor_a,
   output logic               sensor_b,
   output logic               busy,
   output logic               done
);

   // op[0] selects exit direction, op[1] selects the abort variant
   localparam int unsigned OP_W = 2;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PH1  = 3'd1,
      PH2  = 3'd2,
      PH3  = 3'd3,
      GAP  = 3'd4
   } state_t;

   state_t              state, state_n;
   logic [DWELL_W-1:0]  cnt, cnt_n;
   logic [DWELL_W-1:0]  dwell, dwell_n;
   logic [OP_W-1:0]     op, op_n;
   logic [1:0]          ab_n;
   logic                done_n;

   // State register plus registered sensor and done outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         dwell    <= '0;
         op       <= '0;
         sensor_a <= 1'b0;
         sensor_b <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         dwell    <= dwell_n;
         op       <= op_n;
         sensor_a <= ab_n[1];
         sensor_b <= ab_n[0];
         done     <= done_n;
      end
   end

   // Next-state, dwell countdown and the beam pattern for the upcoming state
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      dwell_n = dwell;
      op_n    = op;
      done_n  = 1'b0;
      ab_n    = 2'b00;

      case (state)
         IDLE: begin
            if (cmd_valid) begin
               op_n    = cmd_op;
               dwell_n = cmd_dwell;
               cnt_n   = cmd_dwell;
               state_n = PH1;
            end
         end
         PH1: begin
            if (cnt == '0) begin
               cnt_n   = dwell;
               state_n = op[1] ? GAP : PH2;
            end else begin
               cnt_n = cnt - DWELL_W'(1);
            end
         end
         PH2: begin
            if (cnt == '0) begin
               cnt_n   = dwell;
               state_n = PH3;
            end else begin
               cnt_n = cnt - DWELL_W'(1);
            end
         end
         PH3: begin
            if (cnt == '0) begin
               cnt_n   = dwell;
               state_n = GAP;
            end else begin
               cnt_n = cnt - DWELL_W'(1);
            end
         end
         GAP: begin
            if (cnt == '0) begin
               cnt_n   = '0;
               state_n = IDLE;
               done_n  = 1'b1;
            end else begin
               cnt_n = cnt - DWELL_W'(1);
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase

      // Pattern {a,b} is registered alongside the state so it appears with it
      case (state_n)
         PH1:     ab_n = op_n[0] ? 2'b01 : 2'b10;
         PH2:     ab_n = 2'b11;
         PH3:     ab_n = op_n[0] ? 2'b10 : 2'b01;
         default: ab_n = 2'b00;
      endcase
   end

   // Handshake flags decode the state register only
   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_parking_sensor_gen.sv
// Directed bench for parking_sensor_gen with a small loopback car-detector model.
module tb_parking_sensor_gen;

   localparam int unsigned DWELL_W = 8;

   logic               clk;
   logic               reset;
   logic               cmd_valid;
   logic [1:0]         cmd_op;
   logic [DWELL_W-1:0] cmd_dwell;
   logic               cmd_ready;
   logic               sensor_a;
   logic               sensor_b;
   logic               busy;
   logic               done;

   int tests = 0;
   int fails = 0;

   // loopback detector state
   logic [1:0] prev_pat = 2'b00;
   logic [5:0] hist     = 6'b0;
   int         car_in   = 0;
   int         car_out  = 0;

   parking_sensor_gen #(.DWELL_W(DWELL_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_op    (cmd_op),
      .cmd_dwell (cmd_dwell),
      .cmd_ready (cmd_ready),
      .sensor_a  (sensor_a),
      .sensor_b  (sensor_b),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Car detector: full 10,11,01 path back to 00 is a car in; 01,11,10 is a car out
   always @(negedge clk) begin
      if ({sensor_a, sensor_b} != prev_pat) begin
         if ({sensor_a, sensor_b} == 2'b00) begin
            if (hist == 6'b10_11_01) car_in <= car_in + 1;
            else if (hist == 6'b01_11_10) car_out <= car_out + 1;
            hist <= 6'b0;
         end else begin
            hist <= {hist[3:0], sensor_a, sensor_b};
         end
         prev_pat <= {sensor_a, sensor_b};
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [1:0] ab, input logic d, input logic bz);
      logic [4:0] obs;
      logic [4:0] exp;
      obs = {sensor_a, sensor_b, done, busy, cmd_ready};
      exp = {ab, d, bz, ~bz};
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed {a,b,done,busy,ready}=%b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Check n consecutive busy cycles holding pattern ab
   task automatic phase(input string tag, input logic [1:0] ab, input int n);
      for (int i = 0; i < n; i++) begin
         check(tag, ab, 1'b0, 1'b1);
         tick();
      end
   endtask

   task automatic send(input logic [1:0] op, input logic [DWELL_W-1:0] d);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_dwell = d;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic finish_seq(input string tag);
      check({tag, "_done"}, 2'b00, 1'b1, 1'b0);
      tick();
      check({tag, "_idle"}, 2'b00, 1'b0, 1'b0);
   endtask

   int ci, co;

   initial begin
      reset     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_dwell = '0;

      // 1. reset and idle
      tick();
      check("rst0", 2'b00, 1'b0, 1'b0);
      tick();
      check("rst1", 2'b00, 1'b0, 1'b0);
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("idle", 2'b00, 1'b0, 1'b0);
      end

      // 2. ENTER, D=0
      ci = car_in; co = car_out;
      send(2'b00, 8'd0);
      phase("ent0_p1", 2'b10, 1);
      phase("ent0_p2", 2'b11, 1);
      phase("ent0_p3", 2'b01, 1);
      phase("ent0_gap", 2'b00, 1);
      finish_seq("ent0");
      check_int("ent0_carin", car_in - ci, 1);
      check_int("ent0_carout", car_out - co, 0);

      // 3. EXIT, D=2
      ci = car_in; co = car_out;
      send(2'b01, 8'd2);
      phase("ext2_p1", 2'b01, 3);
      phase("ext2_p2", 2'b11, 3);
      phase("ext2_p3", 2'b10, 3);
      phase("ext2_gap", 2'b00, 3);
      finish_seq("ext2");
      check_int("ext2_carin", car_in - ci, 0);
      check_int("ext2_carout", car_out - co, 1);

      // 4. ENTER_ABORT and EXIT_ABORT, D=1
      ci = car_in; co = car_out;
      send(2'b10, 8'd1);
      phase("eab_p1", 2'b10, 2);
      phase("eab_gap", 2'b00, 2);
      finish_seq("eab");
      send(2'b11, 8'd1);
      phase("xab_p1", 2'b01, 2);
      phase("xab_gap", 2'b00, 2);
      finish_seq("xab");
      check_int("abort_carin", car_in - ci, 0);
      check_int("abort_carout", car_out - co, 0);

      // 5. EXIT held while ENTER D=1 runs, then accepted in the done cycle
      ci = car_in; co = car_out;
      send(2'b00, 8'd1);
      cmd_valid = 1'b1;
      cmd_op    = 2'b01;
      cmd_dwell = 8'd0;
      phase("busy_p1", 2'b10, 2);
      phase("busy_p2", 2'b11, 2);
      phase("busy_p3", 2'b01, 2);
      phase("busy_gap", 2'b00, 2);
      check("b2b_done", 2'b00, 1'b1, 1'b0);
      tick();
      cmd_valid = 1'b0;
      phase("b2b_p1", 2'b01, 1);
      phase("b2b_p2", 2'b11, 1);
      phase("b2b_p3", 2'b10, 1);
      phase("b2b_gap", 2'b00, 1);
      finish_seq("b2b");
      check_int("b2b_carin", car_in - ci, 1);
      check_int("b2b_carout", car_out - co, 1);

      // 6. reset during PH2 of ENTER D=3
      ci = car_in; co = car_out;
      send(2'b00, 8'd3);
      phase("mid_p1", 2'b10, 4);
      phase("mid_p2", 2'b11, 2);
      reset     = 1'b0;
      tick();
      check("mid_rst", 2'b00, 1'b0, 1'b0);
      cmd_valid = 1'b1;
      cmd_op    = 2'b00;
      cmd_dwell = 8'd0;
      tick();
      check("mid_rst_cmd", 2'b00, 1'b0, 1'b0);
      cmd_valid = 1'b0;
      reset     = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("mid_nodone", 2'b00, 1'b0, 1'b0);
      end
      check_int("mid_carin", car_in - ci, 0);
      send(2'b00, 8'd0);
      phase("post_p1", 2'b10, 1);
      phase("post_p2", 2'b11, 1);
      phase("post_p3", 2'b01, 1);
      phase("post_gap", 2'b00, 1);
      finish_seq("post");
      check_int("post_carin", car_in - ci, 1);

      // Maximum dwell: 256 cycles per phase without wrap
      send(2'b11, 8'd255);
      phase("max_p1", 2'b01, 256);
      phase("max_gap", 2'b00, 256);
      finish_seq("max");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/parking_sensor_gen.md
# parking_sensor_gen

Stimulus generator for the two-beam parking-lot car detector: accepts a one-shot command (enter, exit, enter-abort, exit-abort) and drives `sensor_a`/`sensor_b` through the matching beam-interruption sequence with a programmable per-phase dwell. It is the transmitter side of the sensor interface the car-detector FSM receives. It is used for emulation on the board and as a reusable bench driver.

## Interface

Parameters:
- `DWELL_W`, default 8: width of the dwell field and of the internal dwell counter.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-low reset (0 = reset, sampled on the rising edge of `clk`).
- `cmd_valid`  in  1: command request.
- `cmd_op`  in  2: operation.
  - 00 = ENTER
  - 01 = EXIT
  - 10 = ENTER_ABORT
  - 11 = EXIT_ABORT
- `cmd_dwell`  in  DWELL_W: dwell value D; each phase is held D+1 cycles.
- `cmd_ready`  out  1: high only in IDLE; a command is accepted on an edge where `cmd_valid & cmd_ready`.
- `sensor_a`  out  1: registered beam A output; 1 = interrupted.
- `sensor_b`  out  1: registered beam B output; 1 = interrupted.
- `busy`  out  1: high in every state except IDLE (equals `~cmd_ready`).
- `done`  out  1: one-cycle pulse on completion of a sequence.

## Operation

- States: IDLE, PH1, PH2, PH3, GAP.
- Patterns are written as {a,b}.
  - ENTER: PH1=10, PH2=11, PH3=01, then GAP=00.
  - EXIT: PH1=01, PH2=11, PH3=10, then GAP=00.
  - ENTER_ABORT: PH1=10, then GAP=00. PH2 and PH3 are skipped.
  - EXIT_ABORT: PH1=01, then GAP=00. PH2 and PH3 are skipped.
- On accept, the block latches `cmd_op` and `cmd_dwell`, loads the dwell counter with D, and enters PH1.
- In each non-IDLE state the counter decrements once per cycle. When it reads 0, the FSM advances to the next state and reloads D.
- When GAP expires, the FSM returns to IDLE and `done` is asserted for exactly that first IDLE cycle.
- `cmd_valid` while busy is ignored and not queued. `cmd_op`/`cmd_dwell` changes after accept have no effect.
- A command may be accepted in the same cycle `done` is high; the next sequence starts without an extra idle cycle.
- D=0 is legal: every phase lasts 1 cycle. D=2^DWELL_W-1 is legal: 2^DWELL_W cycles per phase, with no wrap or overflow.
- Outputs are never 11 in PH1 or PH3, and never 11 in ENTER_ABORT/EXIT_ABORT.
- Reset (reset=0 at an edge), including mid-sequence:
  - State goes to IDLE; `sensor_a=0`, `sensor_b=0`, `busy=0`, `done=0`, `cmd_ready=1` from that edge on.
  - No `done` pulse is generated for the aborted sequence.
  - A command presented while reset=0 is not accepted.

## Timing

- Reset values: `sensor_a=0`, `sensor_b=0`, `done=0`, `busy=0`, `cmd_ready=1`.
- All outputs are registered, except `cmd_ready`/`busy`, which decode the state register directly with no input-to-output combinational path.
- Cycle numbering: the accept edge is cycle 0, and cycle k is the cycle following edge k.
- ENTER/EXIT with dwell D:
  - PH1 occupies cycles 1..D+1.
  - PH2 occupies cycles D+2..2D+2.
  - PH3 occupies cycles 2D+3..3D+3.
  - GAP (00) occupies cycles 3D+4..4D+4.
  - `done=1` and `cmd_ready=1` at cycle 4D+5.
  - Total latency from accept to `done` is 4D+5.
- ABORT ops:
  - PH1 occupies cycles 1..D+1.
  - GAP occupies cycles D+2..2D+2.
  - `done` at cycle 2D+3.
- The first pattern appears on `sensor_a`/`sensor_b` one cycle after accept. There is no cycle of 00 between accept and PH1.

## Test plan

1. Reset and idle:
   - Stimulus: reset=0 for 2 cycles, then release with `cmd_valid=0`.
   - Response: outputs 00, `cmd_ready=1`, `busy=0`, `done=0` held for 20 cycles.
2. ENTER, D=0:
   - Sensors: 10, 11, 01, 00, one cycle each starting 1 cycle after accept.
   - `done` pulse at cycle 5.
   - Loopback into the car-detector FSM produces exactly one `carIn` and no `carOut`.
3. EXIT, D=2:
   - Sensors: 01 for 3 cycles, 11 for 3, 10 for 3, 00 for 3.
   - `done` at cycle 13.
   - Loopback gives one `carOut`.
4. ENTER_ABORT, D=1:
   - Sensors: 10 for 2 cycles, then 00 for 2 cycles.
   - `done` at cycle 5; loopback gives no `carIn`/`carOut`.
   - Repeat with EXIT_ABORT using pattern 01.
5. Busy and back-to-back:
   - Stimulus: pulse `cmd_valid` with EXIT during an ENTER.
   - Required response: the EXIT is ignored, so sensor outputs are unchanged.
   - Then present `cmd_valid` with EXIT in the `done` cycle.
   - Required response: accepted, and 01 appears on the next cycle.
6. Reset mid-sequence:
   - Stimulus: ENTER with D=3, drive reset=0 during PH2.
   - Response: outputs 00 and `busy=0` from the next edge, no `done` pulse.
   - After release, a new ENTER completes normally.
